mux_reg_scan_ctrl: RTL and testbench

Scan-side controller for the MUX_REG_8x8 page-register bank test port (TC/TD/TQ).
- Drives TC (scan enable) and TD (serial in), and samples TQ (serial out).
- One host request swaps the full chain: CHAIN_LEN new bits are shifted in while the old contents are shifted out and captured.
- Sits between the test/debug host logic and one or more daisy-chained MUX_REG_8x8 scan ports.

---
 rtl/mux_reg_scan_ctrl.sv | 75 +++++++
 tb/tb_mux_reg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_reg_scan_ctrl.sv
// Scan-side controller for the MUX_REG_8x8 test port: one START swaps the whole
// chain, shifting WR_DATA in through TD while the old contents are captured from TQ.
module mux_reg_scan_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] WR_DATA,
  output logic [CHAIN_LEN-1:0] RD_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TC,
  output logic                 TD,
  input  logic                 TQ
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q;
  logic                 tc_q;
  logic [CHAIN_LEN-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            shift_q <= WR_DATA;
            cnt_q   <= '0;
            tc_q    <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q <= {TQ, shift_q[CHAIN_LEN-1:1]};
          // Hold the counter on the final shift so it never passes CHAIN_LEN-1.
          if (cnt_q == LAST_CNT) begin
            tc_q    <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          tc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign TC      = tc_q;
  assign TD      = shift_q[0];
  assign RD_DATA = shift_q;
  assign DONE    = (state_q == ST_DONE);
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_reg_scan_ctrl.sv
// Bench for mux_reg_scan_ctrl: behavioural scan chains attached to a 64-bit and a
// 2-bit controller; a swap is expected to return the old chain and leave WR_DATA in it.
module tb_mux_reg_scan_ctrl;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rstN;
  logic         start;
  logic [N-1:0] wrData;
  logic [N-1:0] rdData;
  logic         busy, done, tc, td, tq;

  logic         start2;
  logic [1:0]   wrData2;
  logic [1:0]   rdData2;
  logic         busy2, done2, tc2, td2, tq2;

  logic [N-1:0] chain;
  logic         presetEn;
  logic [N-1:0] presetVal;
  logic [1:0]   chain2;
  logic         presetEn2;
  logic [1:0]   presetVal2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_reg_scan_ctrl #(.CHAIN_LEN(N), .CNT_W(8)) dut (
    .CLK(clk), .RESET_N(rstN), .START(start), .WR_DATA(wrData), .RD_DATA(rdData),
    .BUSY(busy), .DONE(done), .TC(tc), .TD(td), .TQ(tq)
  );

  mux_reg_scan_ctrl #(.CHAIN_LEN(2), .CNT_W(1)) dutSmall (
    .CLK(clk), .RESET_N(rstN), .START(start2), .WR_DATA(wrData2), .RD_DATA(rdData2),
    .BUSY(busy2), .DONE(done2), .TC(tc2), .TD(td2), .TQ(tq2)
  );

  // Scan chains: shift toward TQ (flop 0) while TC is high; otherwise accept a preset.
  assign tq  = chain[0];
  assign tq2 = chain2[0];

  always @(posedge clk) begin
    if (tc) chain <= {td, chain[N-1:1]};
    else if (presetEn) chain <= presetVal;
    if (tc2) chain2 <= {td2, chain2[1]};
    else if (presetEn2) chain2 <= presetVal2;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic loadChain(input logic [N-1:0] val);
    @(negedge clk);
    presetVal = val;
    presetEn  = 1'b1;
    @(negedge clk);
    presetEn  = 1'b0;
  endtask

  // One full swap: the old chain must come back on RD_DATA and the chain must end up
  // holding what was written, with TC high for N cycles and DONE N+1 cycles after START.
  task automatic applyStimulus(input logic [N-1:0] preset, input logic [N-1:0] wr, input bit poke);
    int k;
    int tcCount;
    bit seen;
    loadChain(preset);
    wrData = wr;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    wrData  = ~wr;
    tcCount = int'(tc);
    seen    = 1'b0;
    for (k = 1; k <= N + 8; k++) begin
      @(posedge clk);
      #1;
      if (poke) begin
        if (k == 10) begin
          start  = 1'b1;
          wrData = $urandom() % 2 == 0 ? ~wr : {wr[N-2:0], ~wr[N-1]};
        end else if (k == 11) begin
          start = 1'b0;
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      tcCount += int'(tc);
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    checkOutput("latency", 64'(k + 1), 64'(N + 1));
    checkOutput("tc_cycles", 64'(tcCount), 64'(N));
    checkOutput("rd_old_chain", rdData, preset);
    checkOutput("chain_new", chain, wr);
    checkOutput("busy_in_done", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_len", 64'(done), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("stay_idle", 64'(busy | done), 64'd0);
    end
    checkOutput("rd_held", rdData, preset);
  endtask

  initial begin
    logic [N-1:0] p, w, expPrev;
    int nd, lastDone, k;
    bit sawDone;

    rstN = 1'b1; start = 1'b0; wrData = '0; presetEn = 1'b0; presetVal = '0;
    start2 = 1'b0; wrData2 = '0; presetEn2 = 1'b0; presetVal2 = '0;

    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_tc", 64'(tc), 64'd0);
    checkOutput("rst_td", 64'(td), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_rd", rdData, 64'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    applyStimulus(64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 1'b0);
    applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()}, ($urandom() % 2) == 1);

    // Back-to-back with START held high: swaps every N+2 cycles, each returns the previous write.
    p = {$urandom(), $urandom()};
    loadChain(p);
    expPrev  = p;
    wrData   = 64'hAAAA_AAAA_AAAA_AAAA;
    start    = 1'b1;
    nd       = 0;
    lastDone = 0;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        checkOutput("b2b_rd", rdData, expPrev);
        checkOutput("b2b_chain", chain, wrData);
        if (nd > 0) checkOutput("b2b_period", 64'(k - lastDone), 64'(N + 2));
        expPrev  = wrData;
        wrData   = ~wrData;
        lastDone = k;
        nd++;
      end
      if (k == 199) start = 1'b0;
      if (k > 199 && !busy) break;
    end
    checkOutput("b2b_swaps", 64'(nd), 64'd4);

    // Reset in the middle of a shift aborts with no DONE.
    loadChain({$urandom(), $urandom()});
    wrData = {$urandom(), $urandom()};
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("abort_tc", 64'(tc), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_rd", rdData, 64'd0);
    sawDone = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      sawDone |= done;
    end
    checkOutput("abort_no_done", 64'(sawDone), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus({$urandom(), $urandom()}, 64'h1, 1'b0);

    // Two-flop chain corner.
    @(negedge clk);
    presetVal2 = 2'b10;
    presetEn2  = 1'b1;
    @(negedge clk);
    presetEn2 = 1'b0;
    wrData2   = 2'b01;
    start2    = 1'b1;
    @(posedge clk);
    #1;
    start2  = 1'b0;
    wrData2 = 2'b11;
    nd      = int'(tc2);
    sawDone = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        sawDone = 1'b1;
        break;
      end
      nd += int'(tc2);
    end
    checkOutput("small_done", 64'(sawDone), 64'd1);
    checkOutput("small_latency", 64'(k + 1), 64'd3);
    checkOutput("small_tc", 64'(nd), 64'd2);
    checkOutput("small_rd", 64'(rdData2), 64'h2);
    checkOutput("small_chain", 64'(chain2), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
